// File: rtl/r2_butterfly_stage_if.sv
// Pair-in / pair-out bus for the radix-2 butterfly stage, including the
// twiddle ROM address/data lines.
interface r2_butterfly_stage_if #(
    parameter int TW_AW = 2
);
    logic             in_valid;
    logic             frame_start;
    logic [31:0]      a;
    logic [31:0]      b;
    logic [TW_AW-1:0] tw_addr;
    logic [15:0]      tw_re;
    logic [15:0]      tw_im;
    logic             out_valid;
    logic [31:0]      x;
    logic [31:0]      y;

    modport slave (
        input  in_valid, frame_start, a, b, tw_re, tw_im,
        output tw_addr, out_valid, x, y
    );

    modport master (
        output in_valid, frame_start, a, b, tw_re, tw_im,
        input  tw_addr, out_valid, x, y
    );
endinterface

// File: rtl/r2_butterfly_stage.sv
// Pipelined radix-2 DIF butterfly: x=(a+b)/2, y=((a-b)*W)/2, three register
// stages, with the twiddle address counter feeding an external sync ROM.
module r2_butterfly_stage #(
    parameter int TW_COUNT = 4,
    parameter int TW_AW    = 2
) (
    input logic                 clk,
    input logic                 rst,
    r2_butterfly_stage_if.slave bus
);
    localparam logic [TW_AW-1:0] LAST_ADDR = TW_AW'(TW_COUNT - 1);

    logic [TW_AW-1:0] cnt;
    logic [TW_AW-1:0] addr;

    logic signed [15:0] a_re, a_im, b_re, b_im, w_re, w_im;

    logic signed [16:0] s_re, s_im, d_re, d_im;
    logic               v1;

    logic signed [32:0] m_rr, m_ii, m_ri, m_ir;
    logic signed [33:0] p_re, p_im;
    logic signed [16:0] s2_re, s2_im;
    logic               v2;

    logic [31:0] x_q, y_q;
    logic        ov_q;

    logic unused_bits;

    function automatic logic [15:0] sat16(input logic signed [33:0] p);
        logic signed [17:0] t;
        t = p[33:16];
        if (t > 18'sd32767)
            return 16'h7FFF;
        else if (t < -18'sd32768)
            return 16'h8000;
        else
            return t[15:0];
    endfunction

    // frame_start only counts when the pair is real; bubbles never move cnt
    always_comb begin
        addr = cnt;
        if (bus.in_valid && bus.frame_start)
            addr = '0;
    end

    assign bus.tw_addr = addr;

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (bus.in_valid)
            cnt <= (addr == LAST_ADDR) ? '0 : addr + 1'b1;
    end

    always_comb begin
        a_re = bus.a[31:16];
        a_im = bus.a[15:0];
        b_re = bus.b[31:16];
        b_im = bus.b[15:0];
        w_re = bus.tw_re;
        w_im = bus.tw_im;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_re <= '0;
            s_im <= '0;
            d_re <= '0;
            d_im <= '0;
            v1   <= 1'b0;
        end else begin
            s_re <= {a_re[15], a_re} + {b_re[15], b_re};
            s_im <= {a_im[15], a_im} + {b_im[15], b_im};
            d_re <= {a_re[15], a_re} - {b_re[15], b_re};
            d_im <= {a_im[15], a_im} - {b_im[15], b_im};
            v1   <= bus.in_valid;
        end
    end

    // ROM data arrives one cycle after the address, aligned with stage-1 regs
    always_comb begin
        m_rr = 33'(d_re) * 33'(w_re);
        m_ii = 33'(d_im) * 33'(w_im);
        m_ri = 33'(d_re) * 33'(w_im);
        m_ir = 33'(d_im) * 33'(w_re);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_re  <= '0;
            p_im  <= '0;
            s2_re <= '0;
            s2_im <= '0;
            v2    <= 1'b0;
        end else begin
            p_re  <= {m_rr[32], m_rr} - {m_ii[32], m_ii};
            p_im  <= {m_ri[32], m_ri} + {m_ir[32], m_ir};
            s2_re <= s_re;
            s2_im <= s_im;
            v2    <= v1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q  <= '0;
            y_q  <= '0;
            ov_q <= 1'b0;
        end else begin
            x_q  <= {s2_re[16:1], s2_im[16:1]};
            y_q  <= {sat16(p_re), sat16(p_im)};
            ov_q <= v2;
        end
    end

    assign bus.x         = x_q;
    assign bus.y         = y_q;
    assign bus.out_valid = ov_q;

    // Bits discarded by the halving shifts
    assign unused_bits = ^{p_re[15:0], p_im[15:0], s2_re[0], s2_im[0]};
endmodule
